// File: rtl/sprite_fetch_sequencer.sv
// sprite_fetch_sequencer: takes one draw request at a time, looks up the sprite
// descriptor, then issues one source read per sprite pixel in row-major order,
// each tagged with its destination screen coordinate.
// Optional feature: define SPRITE_CLIP_EN to skip pixels that fall outside the
// SCREEN_W x SCREEN_H visible area.
module sprite_fetch_sequencer #(
  parameter int ADDR_W      = 25,
  parameter int DIM_W       = 10,
  parameter int ID_W        = 6,
  parameter int NUM_SPRITES = 13,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ID_W-1:0]           req_id,
  input  logic [DIM_W-1:0]          req_x,
  input  logic [DIM_W-1:0]          req_y,
  output logic [ID_W-1:0]           tbl_id,
  input  logic [ADDR_W+2*DIM_W-1:0] tbl_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DIM_W-1:0]          mem_x,
  output logic [DIM_W-1:0]          mem_y,
  output logic                      mem_last,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_LATCH, S_RUN, S_DONE} state_t;

  localparam logic [ID_W:0] NUM_ID = (ID_W+1)'(NUM_SPRITES);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DIM_W-1:0]    x_q, x_d, y_q, y_d;
  logic [DIM_W-1:0]    width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0]    col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [ADDR_W-1:0]   tbl_base;
  logic [DIM_W-1:0]    tbl_w, tbl_h;
  logic                col_end, row_end;
  logic                pix_vis, pix_last;
  logic                beat_acc, empty;

  assign tbl_base = tbl_data[ADDR_W+2*DIM_W-1 -: ADDR_W];
  assign tbl_w    = tbl_data[2*DIM_W-1 -: DIM_W];
  assign tbl_h    = tbl_data[DIM_W-1:0];

  assign col_end  = (col_q == width_q - DIM_W'(1));
  assign row_end  = (row_q == height_q - DIM_W'(1));
  assign empty    = ({1'b0, id_q} >= NUM_ID) || (tbl_w == '0) || (tbl_h == '0);

`ifdef SPRITE_CLIP_EN
  localparam logic [DIM_W:0] SCR_W = (DIM_W+1)'(SCREEN_W);
  localparam logic [DIM_W:0] SCR_H = (DIM_W+1)'(SCREEN_H);
  logic [DIM_W:0] ux, uy;

  // Visibility uses the unwrapped sum; the last visible beat is the one whose
  // right and lower neighbours are either past the sprite or off screen.
  always_comb begin
    ux       = {1'b0, x_q} + {1'b0, col_q};
    uy       = {1'b0, y_q} + {1'b0, row_q};
    pix_vis  = (ux < SCR_W) && (uy < SCR_H);
    pix_last = pix_vis
             && (col_end || ((ux + (DIM_W+1)'(1)) >= SCR_W))
             && (row_end || ((uy + (DIM_W+1)'(1)) >= SCR_H));
  end
`else
  // Without clipping every pixel is issued and the final pixel is the last beat.
  always_comb begin
    pix_vis  = 1'b1;
    pix_last = col_end && row_end;
  end
`endif

  assign req_ready = (state_q == S_IDLE) && Reset_n;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign tbl_id    = id_q;
  assign mem_valid = (state_q == S_RUN) && pix_vis;
  assign mem_last  = (state_q == S_RUN) && pix_last;
  assign mem_addr  = addr_q;
  assign mem_x     = x_q + col_q;
  assign mem_y     = y_q + row_q;
  assign beat_acc  = mem_valid && mem_ready;

  // Next-state and datapath update; registers only move on acceptance or skip,
  // which keeps beat fields stable during back-pressure.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    x_d      = x_q;
    y_d      = y_q;
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          id_d    = req_id;
          x_d     = req_x;
          y_d     = req_y;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_LATCH;
      S_LATCH: begin
        width_d  = tbl_w;
        height_d = tbl_h;
        if (empty) begin
          state_d = S_DONE;
        end else begin
          col_d   = '0;
          row_d   = '0;
          addr_d  = tbl_base;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (beat_acc || !pix_vis) begin
          addr_d = addr_q + ADDR_W'(1);
          if (col_end) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          if ((beat_acc && pix_last) || (!pix_vis && col_end && row_end)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything that drives outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Scoreboard bench for sprite_fetch_sequencer: the driver pushes the expected
// beat list and done timing per draw; a negedge monitor pops and compares.
module tb_sprite_fetch_sequencer;
  localparam int ADDR_W = 25, DIM_W = 10, ID_W = 6, NUM_SPRITES = 13;
  localparam int SCREEN_W = 640, SCREEN_H = 480;
  localparam int TW = ADDR_W + 2*DIM_W;

  logic              Clk = 1'b0, Reset_n = 1'b0;
  logic              req_valid = 1'b0, req_ready;
  logic [ID_W-1:0]   req_id = '0, tbl_id;
  logic [DIM_W-1:0]  req_x = '0, req_y = '0;
  logic [TW-1:0]     tbl_data = '0;
  logic              mem_valid, mem_ready = 1'b1, mem_last, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DIM_W-1:0]  mem_x, mem_y;

  sprite_fetch_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_x(req_x), .req_y(req_y), .tbl_id(tbl_id), .tbl_data(tbl_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_x(mem_x),
    .mem_y(mem_y), .mem_last(mem_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  y;
    logic              last;
  } beat_t;

  logic [TW-1:0] tbl_mem [64];
  beat_t exp_q [$];
  int    dq [$];
  int    cyc = 0, n_chk = 0, n_pass = 0, beats_acc = 0, last_done_cyc = -1;
  int    rmode = 0;
  bit    mon_en = 0;

  initial forever #5 Clk = ~Clk;
  initial forever begin @(posedge Clk); cyc++; end
  initial forever begin @(posedge Clk); tbl_data <= tbl_mem[tbl_id]; end
  initial forever begin
    @(posedge Clk); #1;
    case (rmode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = cyc[0];
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_x"},     mem_x, 0);
    chk({tag, "_mem_y"},     mem_y, 0);
    chk({tag, "_mem_last"},  mem_last, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_tbl_id"},    tbl_id, 0);
  endtask

  // Reference: enumerate the sprite's pixels row by row from its descriptor.
  task automatic model_draw(input int id, input int x, input int y, input int acc, input bit timed);
    logic [TW-1:0] e;
    int base, w, h, n;
    bit empty_desc;
    beat_t b;
    e = tbl_mem[id];
    base = int'(e[TW-1:2*DIM_W]);
    w = int'(e[2*DIM_W-1:DIM_W]);
    h = int'(e[DIM_W-1:0]);
    n = 0;
    empty_desc = (id >= NUM_SPRITES) || (w == 0) || (h == 0);
    if (!empty_desc) begin
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
`ifdef SPRITE_CLIP_EN
          if ((x + c) >= SCREEN_W || (y + r) >= SCREEN_H) continue;
`endif
          b.addr = ADDR_W'(base + r*w + c);
          b.x    = DIM_W'((x + c) % (1 << DIM_W));
          b.y    = DIM_W'((y + r) % (1 << DIM_W));
          b.last = 1'b0;
          exp_q.push_back(b);
          n++;
        end
      end
    end
    if (n > 0) begin
      b = exp_q.pop_back();
      b.last = 1'b1;
      exp_q.push_back(b);
    end
`ifdef SPRITE_CLIP_EN
    if (empty_desc) dq.push_back(acc + 3);
    else dq.push_back(-1);
`else
    if (empty_desc) dq.push_back(acc + 3);
    else if (timed) dq.push_back(acc + 3 + n);
    else dq.push_back(-1);
`endif
  endtask

  task automatic send(input int id, input int x, input int y, input bit keep,
                      input bit timed, output int acc);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_id = ID_W'(id);
    req_x = DIM_W'(x);
    req_y = DIM_W'(y);
    while (!req_ready && t < 20000) begin @(negedge Clk); t++; end
    chk("req_accept_timeout", req_ready, 1);
    acc = cyc;
    model_draw(id, x, y, acc, timed);
    @(negedge Clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge Clk); #1; t++; end
    while ((exp_q.size() != 0 || dq.size() != 0 || busy) && t < 40000);
    chk("draw_complete_timeout", (exp_q.size() == 0 && dq.size() == 0 && !busy), 1);
  endtask

  // Monitor: pops expected beats on acceptance, checks stall stability,
  // done timing and that the request side is closed while busy.
  initial begin
    bit stall_q;
    beat_t sb, b;
    int d;
    stall_q = 0;
    forever begin
      @(negedge Clk);
      if (Reset_n && mon_en) begin
        if (stall_q) begin
          chk("stall_valid_held", mem_valid, 1);
          chk("stall_addr_held", mem_addr, sb.addr);
          chk("stall_x_held", mem_x, sb.x);
          chk("stall_y_held", mem_y, sb.y);
          chk("stall_last_held", mem_last, sb.last);
        end
        if (busy) chk("ready_while_busy", req_ready, 0);
        if (mem_valid && mem_ready) begin
          beats_acc++;
          chk("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk("beat_addr", mem_addr, b.addr);
            chk("beat_x", mem_x, b.x);
            chk("beat_y", mem_y, b.y);
            chk("beat_last", mem_last, b.last);
          end
        end
        stall_q = mem_valid && !mem_ready;
        sb.addr = mem_addr; sb.x = mem_x; sb.y = mem_y; sb.last = mem_last;
        if (done) begin
          chk("done_expected", dq.size() > 0, 1);
          if (dq.size() > 0) begin
            d = dq.pop_front();
            if (d >= 0) chk("done_cycle", cyc, d);
            chk("beats_left_at_done", exp_q.size(), 0);
          end
          last_done_cyc = cyc;
        end
      end else begin
        stall_q = 0;
      end
    end
  end

  initial begin
    int acc, acc2, start, t, id, x, y;
    for (int i = 0; i < 64; i++)
      tbl_mem[i] = {ADDR_W'($urandom), DIM_W'($urandom_range(0, 7)), DIM_W'($urandom_range(0, 7))};
    tbl_mem[0] = {ADDR_W'(307200), DIM_W'(64), DIM_W'(48)};
    tbl_mem[1] = {ADDR_W'(310272), DIM_W'($urandom_range(1, 6)), DIM_W'($urandom_range(1, 6))};
    tbl_mem[3] = {ADDR_W'(1000), DIM_W'(3), DIM_W'(2)};
    tbl_mem[4] = {ADDR_W'(2000), DIM_W'(2), DIM_W'(2)};
    tbl_mem[5] = {ADDR_W'(357834), DIM_W'(60), DIM_W'(100)};
    for (int i = 13; i < 64; i++) tbl_mem[i] = {ADDR_W'(4000 + i), DIM_W'(3), DIM_W'(3)};

    repeat (3) @(negedge Clk);
    #1 chk_reset_vals("por");
    Reset_n = 1'b1;
    #1 chk("ready_after_release", req_ready, 1);
    chk("busy_after_release", busy, 0);
    mon_en = 1;

    // Full 64x48 draw with no back-pressure
    rmode = 0; start = beats_acc;
    send(0, 0, 0, 0, 1, acc);
    wait_idle();
    chk("id0_beat_count", beats_acc - start, 3072);
    chk("id0_done_at", last_done_cyc - acc, 3075);

    // Same draw with mem_ready toggling
    rmode = 1; start = beats_acc;
    send(0, 0, 0, 0, 0, acc);
    wait_idle();
    chk("id0_stall_beat_count", beats_acc - start, 3072);

    // Sprite extending past the right/bottom edge
    rmode = 0; start = beats_acc;
    send(5, 600, 400, 0, 1, acc);
    wait_idle();
`ifdef SPRITE_CLIP_EN
    chk("id5_beat_count", beats_acc - start, 3200);
`else
    chk("id5_beat_count", beats_acc - start, 6000);
`endif

    // Out-of-range ID: no beats, done three cycles after accept
    start = beats_acc;
    send(13, $urandom_range(0, 1023), $urandom_range(0, 1023), 0, 1, acc);
    wait_idle();
    chk("id13_done_at", last_done_cyc - acc, 3);
    chk("id13_beat_count", beats_acc - start, 0);
    chk("id13_ready_cycle_after_done", (cyc == last_done_cyc + 1) && req_ready, 1);

    // Reset in the middle of a draw
    rmode = 0; start = beats_acc;
    send(0, 0, 0, 0, 1, acc);
    t = 0;
    while (beats_acc < start + 100 && t < 1000) begin @(negedge Clk); #1; t++; end
    chk("reach_beat_100", beats_acc - start, 100);
    #2 Reset_n = 1'b0;
    #1 chk_reset_vals("midrun");
    exp_q.delete();
    dq.delete();
    repeat (2) @(negedge Clk);
    #1 Reset_n = 1'b1;
    #1 chk("ready_after_midrun_release", req_ready, 1);
    x = $urandom_range(0, 600); y = $urandom_range(0, 400);
    send(1, x, y, 0, 1, acc);
    wait_idle();

    // Back-to-back requests with req_valid held high
    send(3, 10, 20, 1, 1, acc);
    send(4, 30, 40, 0, 1, acc2);
    chk("b2b_accept_after_done", acc2, last_done_cyc + 1);
    wait_idle();

    // Randomized draws, wrap-around positions and mixed back-pressure
    for (int k = 0; k < 25; k++) begin
      id = $urandom_range(1, 15);
      if (id == 5) id = 6;
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
      rmode = $urandom_range(0, 2);
      send(id, x, y, 0, rmode == 0, acc);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sprite_fetch_sequencer.md
# sprite_fetch_sequencer

Sequences pixel fetches for one sprite draw at a time. Accepts a draw request (sprite ID plus screen position), looks the sprite up in the sprite descriptor table, then streams one source-memory read per sprite pixel in row-major order. Each read carries its destination screen coordinate. Sits between the game-logic draw queue and the SRAM/frame-buffer write path.

## Interface
- ADDR_W, 25, source address width (descriptor base field)
- DIM_W, 10, width/height/coordinate width
- ID_W, 6, sprite ID width
- NUM_SPRITES, 13, IDs at or above this value are treated as empty sprites
- SCREEN_W, 640, visible width (used only with clipping)
- SCREEN_H, 480, visible height (used only with clipping)

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  draw request present
- req_ready  out  1  sequencer idle; request accepted when valid&&ready
- req_id  in  ID_W  sprite ID
- req_x, req_y  in  DIM_W each  screen position of sprite top-left pixel
- tbl_id  out  ID_W  index to descriptor table
- tbl_data  in  ADDR_W+2*DIM_W  {base, width, height}; registered table, valid one cycle after tbl_id
- mem_valid  out  1  fetch beat valid
- mem_ready  in  1  downstream accepts beat
- mem_addr  out  ADDR_W  source pixel address
- mem_x, mem_y  out  DIM_W each  destination coordinate
- mem_last  out  1  final beat of the sprite
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a draw completes

## Operation
- States: IDLE, LOOKUP, LATCH, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On accept, register id/x/y and go to LOOKUP.
- LOOKUP:
  - tbl_id holds the registered ID; the table samples it this cycle.
  - Go to LATCH.
- LATCH:
  - Register base, width and height from tbl_data.
  - If id>=NUM_SPRITES, width==0 or height==0, go to DONE with no beats.
  - Otherwise clear col/row, set addr=base, and go to RUN.
- RUN:
  - Beat fields: mem_addr=addr, mem_x=req_x+col, mem_y=req_y+row.
  - On each accepted beat: addr+=1; col+=1; when col==width-1, col=0 and row+=1.
  - mem_last=1 when col==width-1 and row==height-1. Accepting that beat goes to DONE.
- DONE:
  - done=1 for one cycle, then IDLE.
- Handshake rules:
  - While mem_valid=1 and mem_ready=0, mem_addr, mem_x, mem_y and mem_last hold stable.
  - mem_valid never drops without acceptance, except on reset.
- Arithmetic:
  - Coordinate sums are DIM_W bits and wrap modulo 2^DIM_W when clipping is disabled.
  - The address is ADDR_W bits; wrap is not checked.
- tbl_id is driven with the registered ID in all states; it is 0 after reset.
- Requests arriving while busy are not accepted (req_ready=0) and must be held by the requester.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after release; mem_valid=0, mem_addr=0, mem_x=0, mem_y=0, mem_last=0, busy=0, done=0, tbl_id=0; state IDLE.
- Reset asserted mid-RUN aborts immediately: no done pulse, outputs return to reset values.
- Accept in cycle N:
  - LOOKUP in N+1, LATCH in N+2.
  - First mem_valid in N+3.
  - With mem_ready held high, one beat per cycle; the last beat is in N+2+w*h.
  - done is in the cycle after the last beat.
- Empty sprite: done in N+3, no beats.
- Earliest next accept: the cycle after done (IDLE).

## Configuration
- SPRITE_CLIP_EN defined:
  - In RUN, a pixel whose unwrapped mem_x>=SCREEN_W or mem_y>=SCREEN_H, computed DIM_W+1 bits wide, is skipped.
  - A skipped pixel has mem_valid=0 and advances col/row/addr in one cycle without waiting on mem_ready.
  - mem_last asserts on the last visible beat.
  - If no pixel is visible, no beats are issued and the draw goes to DONE after the scan.
- SPRITE_CLIP_EN not defined:
  - Every pixel is issued.
  - Coordinates wrap as described in Operation.

## Test plan
- ID 0 at (0,0), mem_ready=1, table {307200,64,48}:
  - 3072 beats.
  - Beat 0: addr 307200, (0,0).
  - Beat 64: addr 307264, (0,1).
  - Final beat: addr 310271, (63,47), mem_last=1.
  - done at accept+3075.
- Same draw with mem_ready toggling every other cycle: identical beat sequence, fields stable while stalled, no lost or duplicate beats.
- ID 5 at (600,400), table {357834,60,100}:
  - With SPRITE_CLIP_EN: 3200 beats (x 600..639, y 400..479); last beat addr 357834+79*60+39 with mem_last=1.
  - Without SPRITE_CLIP_EN: 6000 beats.
- ID 13 requested: no mem_valid, done at accept+3, req_ready=1 the cycle after.
- Reset_n pulsed low at beat 100 of an ID 0 draw:
  - Outputs go to reset values asynchronously and no done pulse occurs.
  - A new ID 1 request after release gives first beat addr 310272, (x,y)=request position.
- Back-to-back requests, req_valid held high with two IDs queued:
  - The second is accepted exactly one cycle after the first draw's done.
  - req_ready is never high while busy.
